// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the single evaluation function
// used by both the combinational ALU and the command-stream unit.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Returns {carry, y}. Shifts widen by one bit so the last bit shifted out lands
  // in the extra position; counts >= ALU_W naturally flush the result to zero.
  function automatic logic [ALU_W:0] alu_eval(input logic [ALU_W-1:0] a,
                                               input logic [ALU_W-1:0] b,
                                               input logic [2:0]       sel);
    logic [ALU_W:0] r;
    logic [ALU_W:0] sh;
    r  = '0;
    sh = '0;
    case (sel)
      OP_ADD: r = {1'b0, a} + {1'b0, b};
      OP_SUB: r = {1'b0, a} - {1'b0, b};
      OP_AND: r = {1'b0, a & b};
      OP_OR:  r = {1'b0, a | b};
      OP_XOR: r = {1'b0, a ^ b};
      OP_NOT: r = {1'b0, ~a};
      OP_SHL: r = {1'b0, a} << b;
      OP_SHR: begin
        sh = {a, 1'b0} >> b;
        r  = {sh[0], sh[ALU_W:1]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with extra-MSB pointers: equal pointers mean empty, pointers that
// differ only in the MSB mean full.
module cmd_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; occupancy is defined entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_cmd_unit.sv
// Flow-controlled ALU: commands {A, B, sel} queue in a FIFO, execute into a single
// output register and leave as {Y, carry, zero} results; cmd_count tallies results.
module alu_cmd_unit
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   sel,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] Y,
  output logic         carry,
  output logic         zero,
  output logic [7:0]   cmd_count
);

  localparam int DW = 2 * W + 3;

  // Handshakes: a transfer happens on a rising edge where valid && ready. A source
  // holds valid and its payload until that transfer; ready never depends on valid.

  logic [DW-1:0] fifo_din;
  logic [DW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [W-1:0]  head_a;
  logic [W-1:0]  head_b;
  logic [2:0]    head_sel;
  logic [W:0]    eval;

  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // The output register refills whenever it is empty or being drained this edge.
  assign pop       = !fifo_empty && (!res_valid || res_ready);
  assign fifo_din  = {A, B, sel};
  assign {head_a, head_b, head_sel} = fifo_dout;
  assign eval      = alu_eval(head_a, head_b, head_sel);

  cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      Y         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      cmd_count <= '0;
    end else begin
      if (pop) begin
        res_valid <= 1'b1;
        Y         <= eval[W-1:0];
        carry     <= eval[W];
        zero      <= (eval[W-1:0] == '0);
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (res_valid && res_ready) cmd_count <= cmd_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_unit.sv
// Bench for alu_cmd_unit: directed vector table, backpressure/full, mid-stream
// reset and a 256-result counter wrap, with a queue-based result scoreboard.
module tb_alu_cmd_unit;

  localparam int W  = 4;
  localparam int EW = W + 2;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   sel;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] Y;
  logic         carry;
  logic         zero;
  logic [7:0]   cmd_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results, packed {zero, carry, y}
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] y;
    logic         c;
    logic         z;
  } vec_t;

  vec_t vecs[15];

  alu_cmd_unit #(.W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .Y         (Y),
    .carry     (carry),
    .zero      (zero),
    .cmd_count (cmd_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    logic [W-1:0] y;
    logic         c;
    int           s;
    y = '0;
    c = 1'b0;
    s = 0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); y = s[W-1:0]; c = (s >= (1 << W)); end
      3'd1: begin y = a - b; c = (a < b); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      3'd6: begin
        y = a;
        for (int i = 0; i < int'(b); i++) begin c = y[W-1]; y = {y[W-2:0], 1'b0}; end
      end
      default: begin
        y = a;
        for (int i = 0; i < int'(b); i++) begin c = y[0]; y = {1'b0, y[W-1:1]}; end
      end
    endcase
    return {c, y};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard (samples mid-cycle) ----------------
  always @(negedge clk) begin : sb
    logic [EW-1:0] e;
    logic [W:0]    r;
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(res_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_y", int'(Y), int'(e[W-1:0]));
        chk("sb_carry", int'(carry), int'(e[W]));
        chk("sb_zero", int'(zero), int'(e[W+1]));
      end
    end
    if (rst_n && cmd_valid && cmd_ready) begin
      r = ref_eval(A, B, sel);
      exp_q.push_back({(r[W-1:0] == '0), r});
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after each rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    A         = a;
    B         = b;
    sel       = op;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    res_ready = 1'b1;
    drive_cmd(v.a, v.b, v.op);
    @(negedge clk);
    chk($sformatf("vec%0d_ready", idx), int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_not_early", idx), int'(res_valid), 0);
    step();
    @(negedge clk);
    chk($sformatf("vec%0d_valid", idx), int'(res_valid), 1);
    chk($sformatf("vec%0d_y", idx), int'(Y), int'(v.y));
    chk($sformatf("vec%0d_carry", idx), int'(carry), int'(v.c));
    chk($sformatf("vec%0d_zero", idx), int'(zero), int'(v.z));
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W:0] r;
    int accepted;
    int cycles;
    logic [W-1:0] bp_a[6];
    logic [W-1:0] bp_b[6];
    logic [2:0]   bp_op[6];
    logic         acc;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    A         = '0;
    B         = '0;
    sel       = '0;

    //             a      b      op     y      c     z
    vecs[0]  = '{4'd4,  4'd2, 3'd0, 4'd6,  1'b0, 1'b0};
    vecs[1]  = '{4'd4,  4'd2, 3'd1, 4'd2,  1'b0, 1'b0};
    vecs[2]  = '{4'd4,  4'd2, 3'd2, 4'd0,  1'b0, 1'b1};
    vecs[3]  = '{4'd4,  4'd2, 3'd3, 4'd6,  1'b0, 1'b0};
    vecs[4]  = '{4'd4,  4'd2, 3'd4, 4'd6,  1'b0, 1'b0};
    vecs[5]  = '{4'd4,  4'd2, 3'd5, 4'd11, 1'b0, 1'b0};
    vecs[6]  = '{4'd1,  4'd5, 3'd6, 4'd0,  1'b0, 1'b1};
    vecs[7]  = '{4'd8,  4'd2, 3'd7, 4'd2,  1'b0, 1'b0};
    vecs[8]  = '{4'd8,  4'd5, 3'd7, 4'd0,  1'b0, 1'b1};
    vecs[9]  = '{4'd9,  4'd1, 3'd7, 4'd4,  1'b1, 1'b0};
    vecs[10] = '{4'd15, 4'd1, 3'd0, 4'd0,  1'b1, 1'b1};
    vecs[11] = '{4'd2,  4'd5, 3'd1, 4'd13, 1'b1, 1'b0};
    vecs[12] = '{4'd9,  4'd4, 3'd6, 4'd0,  1'b1, 1'b1};
    vecs[13] = '{4'd9,  4'd4, 3'd7, 4'd0,  1'b1, 1'b1};
    vecs[14] = '{4'd4,  4'd0, 3'd6, 4'd4,  1'b0, 1'b0};

    // Reset values, then idle after release
    step();
    step();
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_y", int'(Y), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_count", int'(cmd_count), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", int'(cmd_ready), 1);
    chk("idle_res_valid", int'(res_valid), 0);
    chk("idle_y", int'(Y), 0);
    chk("idle_count", int'(cmd_count), 0);
    step();

    // Directed vectors with 2-cycle latency check
    for (int i = 0; i < 15; i++) run_vec(i);
    chk("vec_count", int'(cmd_count), 15);

    // Reset mid-stream with 3 commands outstanding
    reset_dut();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(4'(i + 1), 4'd1, 3'd0);
      step();
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_held_valid", int'(res_valid), 1);
    rst_n = 1'b0;
    step();
    step();
    exp_q.delete();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_result", int'(res_valid), 0);
      step();
    end
    chk("midrst_count", int'(cmd_count), 0);

    // Backpressure / full
    reset_dut();
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bp_a[i]  = 4'(i + 3);
      bp_b[i]  = 4'(i + 1);
      bp_op[i] = 3'(i);
    end
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(bp_a[i], bp_b[i], bp_op[i]);
      @(negedge clk);
      acc = cmd_ready;
      chk($sformatf("bp_accept%0d", i), int'(acc), (i < 5) ? 1 : 0);
      if (acc) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", accepted, 5);
    r = ref_eval(bp_a[0], bp_b[0], bp_op[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_low", int'(cmd_ready), 0);
      chk("bp_hold_valid", int'(res_valid), 1);
      chk("bp_hold_y", int'(Y), int'(r[W-1:0]));
      chk("bp_hold_carry", int'(carry), int'(r[W]));
      step();
    end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_drain_valid%0d", i), int'(res_valid), 1);
      step();
    end
    @(negedge clk);
    chk("bp_drain_done", int'(res_valid), 0);
    chk("bp_count", int'(cmd_count), 5);
    chk("bp_queue_empty", exp_q.size(), 0);
    step();

    // Counter wrap: 256 random ADDs streamed back to back
    reset_dut();
    res_ready = 1'b1;
    accepted  = 0;
    cycles    = 0;
    while (accepted < 256 && cycles < 400) begin
      drive_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'd0);
      @(negedge clk);
      if (cmd_ready) accepted++;
      step();
      cycles++;
    end
    cmd_valid = 1'b0;
    chk("wrap_accepted", accepted, 256);
    chk("wrap_throughput_cycles", cycles, 256);
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0 && !res_valid) break;
      step();
    end
    @(negedge clk);
    chk("wrap_queue_empty", exp_q.size(), 0);
    chk("wrap_res_idle", int'(res_valid), 0);
    chk("wrap_count", int'(cmd_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_unit.md
Name: alu_cmd_unit

Overview:
- Sequential command-side counterpart of the 4-bit ALU: accepts operation commands {A, B, sel} over a valid/ready handshake and buffers them in a small FIFO.
- Executes each command with the same 8-operation function set as the ALU and returns each result with flags over a second valid/ready handshake.
- Sits between a command producer (sequencer or test driver) and a result consumer; replaces hand-timed stimulus with a flow-controlled stream.

Parameters:
- W, 4, operand/result width in bits.
- DEPTH, 4, command FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (not full)
- A  in  W  operand A
- B  in  W  operand B
- sel  in  3  operation select
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- Y  out  W  result
- carry  out  1  carry/borrow/shift-out flag
- zero  out  1  Y == 0
- cmd_count  out  8  results delivered since reset, wraps at 255->0

Behaviour:
- Reset: clk is the single clock; rst_n is a synchronous, active-low reset sampled on the rising edge of clk. While rst_n is low at a clock edge:
  - FIFO is emptied.
  - cmd_ready=0 during reset, then 1 on the first cycle after release.
  - res_valid=0, Y=0, carry=0, zero=0, cmd_count=0.
- Reset mid-operation: discards all queued and in-flight commands; no result for them is ever presented.
- Command transfer: occurs when cmd_valid && cmd_ready at the clock edge.
  - cmd_ready = !full; it does not depend on cmd_valid.
  - Full-FIFO boundary: a push and a pop in the same cycle when full is not allowed, because cmd_ready=0 when full.
- Execute stage: a single output register {Y, carry, zero} with res_valid.
  - The register loads from the FIFO head when the FIFO is not empty and (res_valid==0 or res_ready==1).
  - The FIFO pops on that same edge.
- Latency: a command accepted at edge N into an empty FIFO with a free output shows res_valid=1 after edge N+1, i.e. 2 cycles from cmd_valid rising to result visible.
- Throughput: one result per cycle while res_ready is held high.
- Backpressure: while res_valid && !res_ready, Y/carry/zero/res_valid hold stable and the FIFO keeps filling.
- cmd_count increments on each res_valid && res_ready transfer and wraps 255->0.
- Simultaneous events:
  - Push into an empty FIFO plus output free in the same cycle: the command is not bypassed; it enters the FIFO and issues next cycle.
  - Push and pop in the same cycle when not full and not empty: occupancy is unchanged.
- Operations (sel); results are W bits and all arithmetic is modulo 2^W:
  - 000 ADD: Y=A+B, carry=carry-out.
  - 001 SUB: Y=A-B, carry=borrow (A<B).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL: Y=A<<B; carry=last bit shifted out; B>=W gives Y=0 and carry=0 (carry=A[0] when B==W).
  - 111 SHR: Y=A>>B, logical; carry=last bit shifted out; same rule for B>=W (carry=A[W-1] when B==W).
  - carry=0 for the logic ops (AND, OR, XOR, NOT).
  - B==0 on a shift: Y=A, carry=0.
- FIFO pointers: log2(DEPTH)+1 bits; full/empty decided by MSB compare; wrap-around is natural.

Decomposition:
- Package alu_pkg:
  - sel encodings OP_ADD..OP_SHR as 3-bit localparams.
  - a function alu_eval(A, B, sel) returning {carry, Y}, shared with the ALU so both ends match bit-for-bit.
- One sub-module: cmd_fifo (parameterised W*2+3 data width, DEPTH, synchronous active-low reset).
- Execute register, flags and counter stay in the top.

Test Plan:
- Reset then idle: after release, cmd_ready=1, res_valid=0, Y=0, cmd_count=0. Assert rst_n low mid-stream with 3 commands queued: no results afterwards, cmd_count=0.
- Single ops, res_ready=1, A=4, B=2, sel 000..101:
  - Y = 6, 2, 0, 6, 6, 11 respectively.
  - carry=0 for all six.
  - each result appears 2 cycles after the push.
- Shifts:
  - A=1, B=5, sel=110 -> Y=0, carry=0, zero=1.
  - A=8, B=2, sel=111 -> Y=2, carry=0.
  - A=8, B=5, sel=111 -> Y=0, zero=1.
  - A=9, B=1, sel=111 -> Y=4, carry=1.
- Arithmetic flags:
  - A=15, B=1, ADD -> Y=0, carry=1, zero=1.
  - A=2, B=5, SUB -> Y=13, carry=1.
- Backpressure/full: hold res_ready=0 and push 6 commands.
  - cmd_ready drops after 5 accepted (4 in FIFO + 1 in output register).
  - Y stays stable.
  - Release res_ready: all 5 results arrive in order, one per cycle, cmd_count=5.
- Counter wrap: stream 256 ADDs with random operands -> each Y matches the reference model, and cmd_count returns to 0.
